// File: rtl/stream_sum_acc_pkg.sv
// Shared types and constants for the stream accumulator.
// Holds the FSM state enum and the default counter width/saturation value.
package stream_sum_acc_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } acc_state_t;

  localparam int unsigned CNT_W_DEF = 8;

  localparam logic [CNT_W_DEF-1:0] CNT_SAT_DEF =
    {CNT_W_DEF{1'b1}};

endpackage

// File: rtl/adder_32.sv
// Combinational ripple-carry adder (the lab's adder_32 core).
// Ports: a_i, b_i operands; carry_i carry-in; sum_o sum; carry_o carry-out.
module adder_32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  logic [WIDTH:0] w_c;

  assign w_c[0] = carry_i;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum_o[i]  = a_i[i] ^ b_i[i] ^ w_c[i];
    assign w_c[i+1]  = (a_i[i] & b_i[i]) |
                       (w_c[i] & (a_i[i] ^ b_i[i]));
  end

  assign carry_o = w_c[WIDTH];

endmodule

// File: rtl/stream_sum_acc.sv
// Stream accumulator: sums operand beats through adder_32, counts carries.
// Ports: op_* input stream (valid/ready/data/last); res_* result stream.
module stream_sum_acc
  import stream_sum_acc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             op_valid_i,
  output logic             op_ready_o,
  input  logic [WIDTH-1:0] op_data_i,
  input  logic             op_last_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [WIDTH-1:0] res_sum_o,
  output logic [CNT_W-1:0] res_carry_cnt_o,
  output logic [CNT_W-1:0] res_count_o,
  output logic             res_ovf_o
);

  localparam logic [CNT_W-1:0] SAT = {CNT_W{1'b1}};

  acc_state_t       r_state;
  acc_state_t       w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_carry_cnt;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;

  logic [WIDTH-1:0] w_sum;
  logic             w_carry;
  logic             w_accept;
  logic             w_res_hs;
  logic             w_carry_sat;
  logic             w_count_sat;

  adder_32 #(
    .WIDTH(WIDTH)
  ) u_adder (
    .a_i    (r_acc),
    .b_i    (op_data_i),
    .carry_i(1'b0),
    .sum_o  (w_sum),
    .carry_o(w_carry)
  );

  assign op_ready_o  = (r_state == ACC);
  assign res_valid_o = (r_state == DONE);

  assign w_accept = op_valid_i && op_ready_o;
  assign w_res_hs = res_valid_o && res_ready_i;

  assign w_carry_sat = (r_carry_cnt == SAT);
  assign w_count_sat = (r_count == SAT);

  assign res_sum_o       = r_acc;
  assign res_carry_cnt_o = r_carry_cnt;
  assign res_count_o     = r_count;
  assign res_ovf_o       = r_ovf;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ACC: begin
        if (w_accept && op_last_i) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (w_res_hs) begin
          w_state_nxt = ACC;
        end
      end
      default: w_state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ACC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_acc       <= '0;
      r_carry_cnt <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
    end else if (w_res_hs) begin
      r_acc       <= '0;
      r_carry_cnt <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_sum;
      if (w_carry) begin
        if (w_carry_sat) begin
          r_ovf <= 1'b1;
        end else begin
          r_carry_cnt <= r_carry_cnt + CNT_W'(1);
        end
      end
      if (w_count_sat) begin
        r_ovf <= 1'b1;
      end else begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

endmodule
